// File: rtl/audio_sample_frontend_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | audio_sample_frontend_pkg : CCHW shared types for the audio capture path   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package audio_sample_frontend_pkg;

  localparam int AUDIO_IN_W = 24;

  typedef logic signed [15:0] AudioSample_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACK    = 2'd1,
    SETTLE = 2'd2
  } FrontendState_t;

  // Width that holds an exact sum of `channels` signed in_w-bit samples.
  function automatic int sum_width(input int in_w, input int channels);
    return in_w + $clog2(channels) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/audio_sample_frontend_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sample_fifo : synchronous FIFO with level, same-cycle push/pop when full   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [WIDTH-1:0] hold;
  logic             empty;
  logic             full;
  logic             do_pop;
  logic             do_push;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = rd_en && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push  = wr_en && (!full || do_pop);
  assign overflow = wr_en && full && !do_pop;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      hold   <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        hold   <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // When empty, present the most recently popped sample instead of stale RAM.
  assign rd_data = empty ? hold : mem[rd_ptr];
  assign valid   = !empty;
  assign level   = count;

endmodule
`default_nettype wire

// File: rtl/audio_sample_frontend.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | audio_sample_frontend : codec pop FSM, channel sum, saturate, FIFO, meter  |
// | Optional DC-removal stage enabled by defining AUDIO_DC_BLOCK_EN.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module audio_sample_frontend
  import audio_sample_frontend_pkg::*;
#(
  parameter int CHANNELS     = 2,
  parameter int IN_W         = AUDIO_IN_W,
  parameter int OUT_W        = 16,
  parameter int FIFO_DEPTH   = 8,
  parameter int METER_W      = 10,
  parameter int DECAY_PERIOD = 4096,
  parameter int DC_SHIFT     = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          codecReadReady,
  input  logic [CHANNELS*IN_W-1:0]      codecData,
  output logic                          codecRead,
  output logic [OUT_W-1:0]              sampleOut,
  output logic                          sampleValid,
  input  logic                          sampleTake,
  output logic [$clog2(FIFO_DEPTH):0]   fifoLevel,
  output logic [7:0]                    overflowCount,
  output logic                          clipped,
  output logic [METER_W-1:0]            meterLevel
);

  localparam int SUM_W = sum_width(IN_W, CHANNELS);
  localparam int SHIFT = IN_W - OUT_W;
`ifdef AUDIO_DC_BLOCK_EN
  localparam int PRE_W = SUM_W + 1;
`else
  localparam int PRE_W = SUM_W;
`endif
  localparam logic signed [PRE_W-1:0] SAT_MAX = {{(PRE_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [PRE_W-1:0] SAT_MIN = ~SAT_MAX;
  localparam int DW = $clog2(DECAY_PERIOD + 1);

  FrontendState_t state;
  FrontendState_t state_next;
  logic           latch_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    latch_en   = 1'b0;
    codecRead  = 1'b0;
    case (state)
      IDLE: begin
        if (codecReadReady) begin
          latch_en   = 1'b1;
          state_next = ACK;
        end
      end
      ACK: begin
        codecRead  = 1'b1;
        state_next = SETTLE;
      end
      SETTLE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  logic [CHANNELS*IN_W-1:0] latched;
  logic signed [SUM_W-1:0]  sum_comb;
  logic signed [SUM_W-1:0]  sum_q;
  logic                     sum_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      latched <= '0;
    end else if (latch_en) begin
      latched <= codecData;
    end
  end

  always_comb begin
    sum_comb = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      sum_comb = sum_comb + {{(SUM_W-IN_W){latched[c*IN_W+IN_W-1]}}, latched[c*IN_W +: IN_W]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= '0;
      sum_vld <= 1'b0;
    end else begin
      sum_vld <= (state == ACK);
      if (state == ACK) begin
        sum_q <= sum_comb;
      end
    end
  end

  logic signed [PRE_W-1:0] pre_val;
  logic                    pre_vld;

`ifdef AUDIO_DC_BLOCK_EN
  localparam int ACC_W = PRE_W + DC_SHIFT;

  logic signed [ACC_W-1:0] dc_acc;
  logic signed [PRE_W-1:0] dc_y;

  // Integer part of the accumulator is its top PRE_W bits (acc >>> DC_SHIFT).
  assign dc_y = {sum_q[SUM_W-1], sum_q} - dc_acc[ACC_W-1 -: PRE_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      dc_acc  <= '0;
      pre_val <= '0;
      pre_vld <= 1'b0;
    end else begin
      pre_vld <= sum_vld;
      if (sum_vld) begin
        pre_val <= dc_y;
        dc_acc  <= dc_acc + {{DC_SHIFT{dc_y[PRE_W-1]}}, dc_y};
      end
    end
  end
`else
  assign pre_val = sum_q;
  assign pre_vld = sum_vld;
`endif

  logic signed [PRE_W-1:0] shifted;
  logic [OUT_W-1:0]        sat_val;
  logic                    sat_hit;
  logic [OUT_W-2:0]        mag;
  logic [METER_W-1:0]      meter_new;

  always_comb begin
    shifted = pre_val >>> SHIFT;
    sat_val = shifted[OUT_W-1:0];
    sat_hit = 1'b0;
    if (shifted > SAT_MAX) begin
      sat_val = {1'b0, {(OUT_W-1){1'b1}}};
      sat_hit = 1'b1;
    end else if (shifted < SAT_MIN) begin
      sat_val = {1'b1, {(OUT_W-1){1'b0}}};
      sat_hit = 1'b1;
    end
  end

  always_comb begin
    mag = sat_val[OUT_W-2:0];
    if (sat_val[OUT_W-1]) begin
      // The most-negative code has no positive twin; clamp it to full scale.
      if (sat_val[OUT_W-2:0] == '0) begin
        mag = {(OUT_W-1){1'b1}};
      end else begin
        mag = (OUT_W-1)'(-sat_val);
      end
    end
    meter_new = METER_W'(mag >> (OUT_W-1-METER_W));
  end

  logic fifo_overflow;

  sample_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (pre_vld),
    .wr_data  (sat_val),
    .rd_en    (sampleTake),
    .rd_data  (sampleOut),
    .valid    (sampleValid),
    .level    (fifoLevel),
    .overflow (fifo_overflow)
  );

  assign clipped = pre_vld && sat_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      overflowCount <= '0;
    end else if (fifo_overflow && (overflowCount != 8'hFF)) begin
      overflowCount <= overflowCount + 1'b1;
    end
  end

  logic [DW-1:0] decay_cnt;
  logic          decay_tick;

  assign decay_tick = (decay_cnt == DW'(DECAY_PERIOD - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      decay_cnt <= '0;
    end else if (decay_tick) begin
      decay_cnt <= '0;
    end else begin
      decay_cnt <= decay_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meterLevel <= '0;
    end else if (pre_vld && (meter_new > meterLevel)) begin
      meterLevel <= meter_new;
    end else if (decay_tick && (meterLevel != '0)) begin
      meterLevel <= meterLevel - 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_audio_sample_frontend.sv
`default_nettype none
// Directed bench for audio_sample_frontend (default build: no DC stage, latency 3).
module tb_audio_sample_frontend;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        codecReadReady = 1'b0;
  logic [47:0] codecData = '0;
  logic        codecRead;
  logic [15:0] sampleOut;
  logic        sampleValid;
  logic        sampleTake = 1'b0;
  logic [3:0]  fifoLevel;
  logic [7:0]  overflowCount;
  logic        clipped;
  logic [9:0]  meterLevel;

  int vectors = 0;
  int miscompares = 0;

  audio_sample_frontend #(
    .CHANNELS     (2),
    .IN_W         (24),
    .OUT_W        (16),
    .FIFO_DEPTH   (8),
    .METER_W      (10),
    .DECAY_PERIOD (16),
    .DC_SHIFT     (10)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .codecReadReady (codecReadReady),
    .codecData      (codecData),
    .codecRead      (codecRead),
    .sampleOut      (sampleOut),
    .sampleValid    (sampleValid),
    .sampleTake     (sampleTake),
    .fifoLevel      (fifoLevel),
    .overflowCount  (overflowCount),
    .clipped        (clipped),
    .meterLevel     (meterLevel)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    codecReadReady = 1'b0;
    sampleTake = 1'b0;
    repeat (2) step();
    rst = 1'b0;
  endtask

  // Presents one sample in IDLE; returns at the ACK-cycle sample point.
  task automatic issue(input logic [23:0] l, input logic [23:0] r);
    codecData = {r, l};
    codecReadReady = 1'b1;
    step();
    codecReadReady = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    vectors++;
    if ({codecRead, sampleOut, sampleValid, fifoLevel, overflowCount, clipped, meterLevel} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got rd=%b out=%h v=%b lvl=%0d ovf=%0d clip=%b meter=%h, want all 0",
               codecRead, sampleOut, sampleValid, fifoLevel, overflowCount, clipped, meterLevel);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    issue(24'h001000, 24'h002000);
    vectors++;
    if (codecRead !== 1'b1 || sampleValid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_c1: got rd=%b v=%b, want rd=1 v=0", codecRead, sampleValid);
    end
    step();
    vectors++;
    if (codecRead !== 1'b0 || clipped !== 1'b0 || sampleValid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_c2: got rd=%b clip=%b v=%b, want 0 0 0", codecRead, clipped, sampleValid);
    end
    step();
    vectors++;
    if (sampleValid !== 1'b1 || sampleOut !== 16'h0030 || fifoLevel !== 4'd1) begin
      miscompares++;
      $display("FAIL basic_c3: got v=%b out=%h lvl=%0d, want v=1 out=0030 lvl=1", sampleValid, sampleOut, fifoLevel);
    end
    sampleTake = 1'b1;
    step();
    sampleTake = 1'b0;
    vectors++;
    if (sampleValid !== 1'b0 || fifoLevel !== 4'd0 || sampleOut !== 16'h0030) begin
      miscompares++;
      $display("FAIL basic_take: got v=%b lvl=%0d out=%h, want v=0 lvl=0 out=0030", sampleValid, fifoLevel, sampleOut);
    end
  endtask

  task automatic test_saturation();
    logic [23:0] ins [2];
    logic [15:0] outs [2];
    ins[0] = 24'h7FFFFF; outs[0] = 16'h7FFF;
    ins[1] = 24'h800000; outs[1] = 16'h8000;
    for (int k = 0; k < 2; k++) begin
      do_reset();
      issue(ins[k], ins[k]);
      step();
      vectors++;
      if (clipped !== 1'b1) begin
        miscompares++;
        $display("FAIL sat_clip_%0d: got clipped=%b, want 1", k, clipped);
      end
      step();
      vectors++;
      if (sampleOut !== outs[k] || meterLevel !== 10'h3FF || clipped !== 1'b0 || sampleValid !== 1'b1) begin
        miscompares++;
        $display("FAIL sat_out_%0d: got out=%h meter=%h clip=%b v=%b, want out=%h meter=3ff clip=0 v=1",
                 k, sampleOut, meterLevel, clipped, sampleValid, outs[k]);
      end
    end
  endtask

  task automatic test_overflow();
    int cyc = 0;
    int last = 0;
    int pulses = 0;
    do_reset();
    codecData = {24'h000000, 24'h000100};
    codecReadReady = 1'b1;
    while (pulses < 12 && cyc < 100) begin
      step();
      cyc++;
      if (codecRead === 1'b1) begin
        pulses++;
        if (pulses > 1) begin
          vectors++;
          if (cyc - last != 3) begin
            miscompares++;
            $display("FAIL pop_spacing: got %0d cycles, want 3", cyc - last);
          end
        end
        last = cyc;
      end
    end
    codecReadReady = 1'b0;
    vectors++;
    if (pulses != 12) begin
      miscompares++;
      $display("FAIL pop_count: got %0d pulses before timeout, want 12", pulses);
    end
    repeat (6) step();
    vectors++;
    if (fifoLevel !== 4'd8 || overflowCount !== 8'd4 || sampleValid !== 1'b1 || sampleOut !== 16'h0001) begin
      miscompares++;
      $display("FAIL overflow_state: got lvl=%0d ovf=%0d v=%b out=%h, want lvl=8 ovf=4 v=1 out=0001",
               fifoLevel, overflowCount, sampleValid, sampleOut);
    end
  endtask

  task automatic test_full_take();
    issue(24'h000200, 24'h000000);
    step();
    sampleTake = 1'b1;
    step();
    sampleTake = 1'b0;
    vectors++;
    if (fifoLevel !== 4'd8 || overflowCount !== 8'd4) begin
      miscompares++;
      $display("FAIL full_take: got lvl=%0d ovf=%0d, want lvl=8 ovf=4", fifoLevel, overflowCount);
    end
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (sampleOut !== ((i < 7) ? 16'h0001 : 16'h0002)) begin
        miscompares++;
        $display("FAIL drain_%0d: got out=%h, want %h", i, sampleOut, (i < 7) ? 16'h0001 : 16'h0002);
      end
      sampleTake = 1'b1;
      step();
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (fifoLevel !== 4'd0) begin
        miscompares++;
        $display("FAIL empty_take_%0d: got lvl=%0d, want 0", i, fifoLevel);
      end
      step();
    end
    sampleTake = 1'b0;
    vectors++;
    if (sampleValid !== 1'b0 || sampleOut !== 16'h0002 || fifoLevel !== 4'd0) begin
      miscompares++;
      $display("FAIL empty_hold: got v=%b out=%h lvl=%0d, want v=0 out=0002 lvl=0", sampleValid, sampleOut, fifoLevel);
    end
  endtask

  task automatic test_meter_decay();
    do_reset();
    issue(24'h400000, 24'h000000);
    repeat (2) step();
    vectors++;
    if (meterLevel !== 10'h200) begin
      miscompares++;
      $display("FAIL meter_load: got %h, want 200", meterLevel);
    end
    repeat (16) step();
    vectors++;
    if (meterLevel !== 10'h1FF) begin
      miscompares++;
      $display("FAIL meter_decay_1: got %h, want 1ff", meterLevel);
    end
    repeat (160) step();
    vectors++;
    if (meterLevel !== 10'h1F5) begin
      miscompares++;
      $display("FAIL meter_decay_11: got %h, want 1f5", meterLevel);
    end
    repeat (8200) step();
    vectors++;
    if (meterLevel !== 10'h000) begin
      miscompares++;
      $display("FAIL meter_floor: got %h, want 000", meterLevel);
    end
    repeat (20) step();
    vectors++;
    if (meterLevel !== 10'h000) begin
      miscompares++;
      $display("FAIL meter_hold0: got %h, want 000", meterLevel);
    end
    issue(24'h010000, 24'h000000);
    repeat (2) step();
    vectors++;
    if (meterLevel !== 10'h008) begin
      miscompares++;
      $display("FAIL meter_reload: got %h, want 008", meterLevel);
    end
  endtask

  task automatic test_reset_in_ack();
    do_reset();
    issue(24'h001000, 24'h002000);
    vectors++;
    if (codecRead !== 1'b1) begin
      miscompares++;
      $display("FAIL ack_pulse: got rd=%b, want 1", codecRead);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    vectors++;
    if (codecRead !== 1'b0) begin
      miscompares++;
      $display("FAIL ack_reset_rd: got rd=%b, want 0", codecRead);
    end
    repeat (6) step();
    vectors++;
    if (sampleValid !== 1'b0 || fifoLevel !== 4'd0 || sampleOut !== 16'h0000 || codecRead !== 1'b0) begin
      miscompares++;
      $display("FAIL ack_reset_discard: got v=%b lvl=%0d out=%h rd=%b, want 0 0 0000 0",
               sampleValid, fifoLevel, sampleOut, codecRead);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_overflow();
    test_full_take();
    test_meter_decay();
    test_reset_in_ack();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
